// File: rtl/sfr_serial_tx.sv
// SFR write mirror: captures one-hot SFR stores into a small FIFO and shifts each
// {index, value} entry out as a 21-bit framed serial word (start 0, stop 1).
module sfr_serial_tx #(
  parameter int DEPTH = 4,
  parameter int DIV   = 4
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic [63:0]              data,
  input  logic [31:0]              address,
  input  logic                     mem_write,
  output logic                     ser_out,
  output logic                     busy,
  output logic                     fifo_empty,
  output logic                     fifo_full,
  output logic [$clog2(DEPTH):0]   fifo_count,
  output logic                     overflow
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;
  localparam int DW = (DIV > 1) ? $clog2(DIV) : 1;

  typedef enum logic {IDLE, SHIFT} state_t;

  state_t          state_q, state_d;
  logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [18:0]     mem_q [DEPTH];
  logic [19:0]     shift_q, shift_d;
  logic [DW-1:0]   div_cnt_q, div_cnt_d;
  logic [4:0]      bit_cnt_q, bit_cnt_d;
  logic            ser_out_q, ser_out_d;
  logic            busy_q, busy_d;
  logic            overflow_q, overflow_d;

  logic [7:0]      sel;
  logic [2:0]      sel_idx;
  logic            wr_req;
  logic            push;
  logic            pop;
  logic            drop;
  logic [18:0]     head;
  logic            unused_ok;

  assign unused_ok = ^{data[63:16], address[31:19], address[9:0]};

  assign sel    = address[17:10];
  assign wr_req = mem_write && (|sel);
  assign head   = mem_q[rd_ptr_q[AW-1:0]];

  assign fifo_count = wr_ptr_q - rd_ptr_q;
  assign fifo_empty = (wr_ptr_q == rd_ptr_q);
  assign fifo_full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                      (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);

  // Lowest set select bit wins when several are asserted.
  always_comb begin
    sel_idx = 3'd0;
    for (int i = 7; i >= 0; i--) begin
      if (sel[i]) sel_idx = 3'(i);
    end
  end

  always_comb begin
    state_d   = state_q;
    shift_d   = shift_q;
    div_cnt_d = div_cnt_q;
    bit_cnt_d = bit_cnt_q;
    ser_out_d = ser_out_q;
    busy_d    = busy_q;
    pop       = 1'b0;

    case (state_q)
      IDLE: begin
        if (!fifo_empty) pop = 1'b1;
      end
      SHIFT: begin
        if (div_cnt_q == DW'(DIV - 1)) begin
          div_cnt_d = '0;
          if (bit_cnt_q == 5'd20) begin
            if (!fifo_empty) begin
              pop = 1'b1;
            end else begin
              state_d   = IDLE;
              ser_out_d = 1'b1;
              busy_d    = 1'b0;
            end
          end else begin
            bit_cnt_d = bit_cnt_q + 5'd1;
            ser_out_d = shift_q[0];
            shift_d   = {1'b1, shift_q[19:1]};
          end
        end else begin
          div_cnt_d = div_cnt_q + DW'(1);
        end
      end
      default: state_d = IDLE;
    endcase

    // Popping drives the start bit now; the remaining 20 bits wait in shift_q.
    if (pop) begin
      state_d   = SHIFT;
      ser_out_d = 1'b0;
      busy_d    = 1'b1;
      div_cnt_d = '0;
      bit_cnt_d = '0;
      shift_d   = {1'b1, head[15:0], head[18:16]};
    end
  end

  always_comb begin
    push       = wr_req && (!fifo_full || pop);
    drop       = wr_req && fifo_full && !pop;
    wr_ptr_d   = wr_ptr_q + PW'(push);
    rd_ptr_d   = rd_ptr_q + PW'(pop);
    overflow_d = overflow_q;
    if (drop) begin
      overflow_d = 1'b1;
    end else if (mem_write && address[18]) begin
      overflow_d = 1'b0;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q    <= IDLE;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      shift_q    <= '1;
      div_cnt_q  <= '0;
      bit_cnt_q  <= '0;
      ser_out_q  <= 1'b1;
      busy_q     <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      shift_q    <= shift_d;
      div_cnt_q  <= div_cnt_d;
      bit_cnt_q  <= bit_cnt_d;
      ser_out_q  <= ser_out_d;
      busy_q     <= busy_d;
      overflow_q <= overflow_d;
    end
  end

  always_ff @(posedge clock) begin
    if (push) mem_q[wr_ptr_q[AW-1:0]] <= {sel_idx, data[15:0]};
  end

  assign ser_out  = ser_out_q;
  assign busy     = busy_q;
  assign overflow = overflow_q;

endmodule

// File: tb/tb_sfr_serial_tx.sv
// Bench for sfr_serial_tx: directed scenarios plus random SFR traffic, all checked
// cycle by cycle against a queue-based model of the FIFO and the serial line.
module tb_sfr_serial_tx;

  localparam int DEPTH = 4;
  localparam int DIV   = 4;

  logic        clock;
  logic        reset;
  logic [63:0] data;
  logic [31:0] address;
  logic        mem_write;
  logic        ser_out;
  logic        busy;
  logic        fifo_empty;
  logic        fifo_full;
  logic [2:0]  fifo_count;
  logic        overflow;

  int checks;
  int errors;

  logic [18:0] m_fifo[$];
  bit          m_line[$];
  bit          m_ovf;

  sfr_serial_tx #(.DEPTH(DEPTH), .DIV(DIV)) dut (
    .clock      (clock),
    .reset      (reset),
    .data       (data),
    .address    (address),
    .mem_write  (mem_write),
    .ser_out    (ser_out),
    .busy       (busy),
    .fifo_empty (fifo_empty),
    .fifo_full  (fifo_full),
    .fifo_count (fifo_count),
    .overflow   (overflow)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  function automatic int lowestSel(input logic [31:0] addr);
    for (int i = 0; i < 8; i++) begin
      if (addr[10+i]) return i;
    end
    return -1;
  endfunction

  // The line queue holds the value ser_out takes in each upcoming cycle of the frame.
  task automatic modelEdge(input logic mw, input logic [31:0] addr, input logic [15:0] d);
    logic [18:0] e;
    int          idx;
    bit          dropped;
    dropped = 0;
    if (m_line.size() > 0) void'(m_line.pop_front());
    if (m_line.size() == 0 && m_fifo.size() > 0) begin
      e = m_fifo.pop_front();
      for (int b = 0; b < 21; b++) begin
        bit v;
        if (b == 0)      v = 1'b0;
        else if (b < 4)  v = e[16 + b - 1];
        else if (b < 20) v = e[b - 4];
        else             v = 1'b1;
        for (int k = 0; k < DIV; k++) m_line.push_back(v);
      end
    end
    idx = lowestSel(addr);
    if (mw && idx >= 0) begin
      if (m_fifo.size() < DEPTH) m_fifo.push_back({3'(idx), d});
      else begin
        m_ovf   = 1'b1;
        dropped = 1;
      end
    end
    if (mw && addr[18] && !dropped) m_ovf = 1'b0;
  endtask

  task automatic compareAll();
    checkOutput("ser_out",    ser_out,    (m_line.size() > 0) ? 32'(m_line[0]) : 32'd1);
    checkOutput("busy",       busy,       32'(m_line.size() > 0));
    checkOutput("fifo_count", fifo_count, 32'(m_fifo.size()));
    checkOutput("fifo_empty", fifo_empty, 32'(m_fifo.size() == 0));
    checkOutput("fifo_full",  fifo_full,  32'(m_fifo.size() == DEPTH));
    checkOutput("overflow",   overflow,   32'(m_ovf));
  endtask

  task automatic applyStimulus(input logic mw, input logic [31:0] addr, input logic [15:0] d);
    mem_write = mw;
    address   = addr;
    data      = {16'($urandom), 32'($urandom), d};
    @(posedge clock);
    modelEdge(mw, addr, d);
    @(negedge clock);
    compareAll();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) applyStimulus(1'b0, 32'($urandom), 16'($urandom));
  endtask

  task automatic waitIdle(input string tag, input int bound, output int busy_cycles);
    int n;
    n = 0;
    busy_cycles = 0;
    while (m_line.size() > 0 || m_fifo.size() > 0) begin
      if (n >= bound) begin
        checkOutput({tag, "_timeout"}, 32'd1, 32'd0);
        return;
      end
      applyStimulus(1'b0, 32'h0, 16'h0);
      if (busy) busy_cycles++;
      n++;
    end
  endtask

  task automatic modelReset();
    m_fifo.delete();
    m_line.delete();
    m_ovf = 1'b0;
  endtask

  initial begin
    int cyc;
    int n;
    checks    = 0;
    errors    = 0;
    reset     = 1'b0;
    mem_write = 1'b0;
    address   = '0;
    data      = '0;
    modelReset();

    #12;
    checkOutput("rst_ser_out",    ser_out,    1);
    checkOutput("rst_busy",       busy,       0);
    checkOutput("rst_fifo_empty", fifo_empty, 1);
    checkOutput("rst_fifo_full",  fifo_full,  0);
    checkOutput("rst_fifo_count", fifo_count, 0);
    checkOutput("rst_overflow",   overflow,   0);
    @(negedge clock);
    reset = 1'b1;

    $display("[TB] non-SFR store");
    applyStimulus(1'b1, 32'h0000_0004, 16'hFFFF);
    idle(3);
    checkOutput("nonsfr_empty", fifo_empty, 1);
    checkOutput("nonsfr_line",  ser_out,    1);

    $display("[TB] single write");
    applyStimulus(1'b1, 32'h0000_0800, 16'hA5C3);
    waitIdle("single", 200, cyc);
    checkOutput("single_busy_cycles", 32'(cyc), 32'd84);

    $display("[TB] priority decode");
    applyStimulus(1'b1, 32'h0000_9000, 16'h0001);
    checkOutput("prio_count", fifo_count, 1);
    waitIdle("prio", 200, cyc);

    $display("[TB] fill and overflow");
    for (int i = 0; i < 6; i++) applyStimulus(1'b1, 32'(1) << (10 + i), 16'(i + 1));
    checkOutput("fill_overflow", overflow,  1);
    checkOutput("fill_full",     fifo_full, 1);
    applyStimulus(1'b1, 32'h0004_0000, 16'h0);
    checkOutput("ovf_clear", overflow, 0);
    n = 0;
    while (m_line.size() != 1 && n < 200) begin
      applyStimulus(1'b0, 32'h0, 16'h0);
      n++;
    end
    checkOutput("frame_end_reached", 32'(m_line.size()), 32'd1);
    applyStimulus(1'b1, 32'h0002_0000, 16'h0077);
    checkOutput("pushpop_count",    fifo_count, 4);
    checkOutput("pushpop_overflow", overflow,   0);
    waitIdle("drain", 1000, cyc);

    $display("[TB] reset mid-frame");
    for (int i = 0; i < 3; i++) applyStimulus(1'b1, 32'h0000_0400, 16'(16'h1111 * (i + 1)));
    idle(30);
    #2 reset = 1'b0;
    #1;
    checkOutput("midrst_ser_out",    ser_out,    1);
    checkOutput("midrst_busy",       busy,       0);
    checkOutput("midrst_fifo_count", fifo_count, 0);
    modelReset();
    @(negedge clock);
    @(negedge clock);
    reset = 1'b1;
    idle(2);

    $display("[TB] random traffic");
    for (int i = 0; i < 3000; i++) begin
      logic        mw;
      logic [31:0] a;
      int          r;
      mw = ($urandom_range(0, 11) == 0) || ((i / 400) % 2 == 1 && $urandom_range(0, 3) == 0);
      r  = $urandom_range(0, 9);
      if (r <= 5)      a = 32'(1) << (10 + $urandom_range(0, 7));
      else if (r == 6) a = {14'($urandom), 8'($urandom), 10'($urandom)};
      else if (r == 7) a = 32'h0004_0000 | ($urandom_range(0, 1) ? (32'(1) << (10 + $urandom_range(0, 7))) : 32'h0);
      else if (r == 8) a = 32'($urandom_range(0, 1023));
      else             a = $urandom;
      applyStimulus(mw, a, 16'($urandom));
    end
    waitIdle("final", 2000, cyc);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
